tpu_shared_res_arbiter: RTL

//  Grants exclusive ownership of the shared weight block ROM and TPU_MultAdd to one FC-layer engine
//  at a time, replacing z-driven enable muxing with registered one-hot grants.

---
 rtl/tpu_shared_res_arbiter_pkg.sv | 22 ++
 rtl/tpu_shared_res_arbiter_rr_pick.sv | 29 ++
 rtl/tpu_shared_res_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_shared_res_arbiter_pkg.sv
// Shared types and defaults for the TPU shared-resource arbiter.
package tpu_shared_res_arbiter_pkg;

    localparam int NUM_REQ_MAX = 4;
    localparam int OWNER_W     = 2;
    localparam int ADDR_W_DEF  = 11;
    localparam int ROM_W_DEF   = 1024;
    localparam int OPR_W_DEF   = 1024;
    localparam int RES_W_DEF   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                   input int num_req);
        return (int'(idx) == num_req - 1) ? '0 : idx + OWNER_W'(1);
    endfunction

endpackage

// File: rtl/tpu_shared_res_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr_i, wrapping.
module tpu_shared_res_arbiter_rr_pick
    import tpu_shared_res_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [OWNER_W-1:0] idx_o,
    output logic               any_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_o && req_i[j] && (j == (int'(ptr_i) + i) % NUM_REQ)) begin
                    any_o       = 1'b1;
                    onehot_o[j] = 1'b1;
                    idx_o       = OWNER_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tpu_shared_res_arbiter.sv
// Lock-style round-robin owner of block ROM and MultAdd for the FC engines,
// with a ROM return tag pipe so read data follows its issuer across hand-overs.
// state | meaning
// IDLE  | no owner, arbitrate every enabled cycle
// GRANT | owner holds gnt until it drops req
// DRAIN | grant released, wait for in-flight ROM reads, then arbitrate
module tpu_shared_res_arbiter
    import tpu_shared_res_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ROM_W   = ROM_W_DEF,
    parameter int OPR_W   = OPR_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int ROM_LAT = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      iRst,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        rd_en,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*OPR_W-1:0]  opr1,
    input  logic [NUM_REQ*OPR_W-1:0]  opr2,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [ROM_W-1:0]          rom_dout,
    output logic [ROM_W-1:0]          rom_rdata,
    output logic [NUM_REQ-1:0]        rom_rvalid,
    output logic [OPR_W-1:0]          mac_opr1,
    output logic [OPR_W-1:0]          mac_opr2,
    input  logic [RES_W-1:0]          mac_dout,
    input  logic                      mac_ovf_in,
    output logic [RES_W-1:0]          mac_res,
    output logic                      mac_ovf,
    output logic [NUM_REQ-1:0]        mac_valid,
    output logic [OWNER_W-1:0]        owner,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int HOLD_W = $clog2(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT - 1);
    localparam int DRN_W = 2;

    arb_state_e                      state_q, state_d;
    logic [NUM_REQ-1:0]              gnt_q, gnt_d;
    logic [OWNER_W-1:0]              owner_q, owner_d;
    logic [OWNER_W-1:0]              ptr_q, ptr_d;
    logic [HOLD_W-1:0]               hold_q, hold_d;
    logic [DRN_W-1:0]                drain_q, drain_d;
    logic                            err_q, err_d;
    logic [ROM_LAT-1:0]              tag_v_q;
    logic [ROM_LAT-1:0][OWNER_W-1:0] tag_o_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic               granted, req_own, rd_own, hold_hit, arb_go, pipe_busy;
    logic [ADDR_W-1:0]  addr_own;
    logic [OPR_W-1:0]   opr1_own, opr2_own;

    tpu_shared_res_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        req_own  = 1'b0;
        rd_own   = 1'b0;
        addr_own = '0;
        opr1_own = '0;
        opr2_own = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                req_own  = req[i];
                rd_own   = rd_en[i];
                addr_own = addr[i*ADDR_W +: ADDR_W];
                opr1_own = opr1[i*OPR_W +: OPR_W];
                opr2_own = opr2[i*OPR_W +: OPR_W];
            end
        end
    end

    assign granted   = (state_q == ST_GRANT);
    assign hold_hit  = granted && (hold_q == HOLD_MAX);
    assign pipe_busy = |tag_v_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        drain_d = drain_q;
        err_d   = err_q | hold_hit;
        arb_go  = 1'b0;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: arb_go = 1'b1;
                ST_GRANT: begin
                    if (!req_own) begin
                        state_d = ST_DRAIN;
                        gnt_d   = '0;
                        drain_d = DRN_W'(ROM_LAT);
                    end else if (!hold_hit) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q != '0) begin
                        drain_d = drain_q - DRN_W'(1);
                    end else if (!pipe_busy) begin
                        arb_go = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (arb_go) begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = rr_next(pick_idx, NUM_REQ);
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Tag pipe tracks which requester issued each read so data returns to it after a hand-over.
    always_ff @(posedge clk) begin
        if (iRst) begin
            tag_v_q <= '0;
            tag_o_q <= '0;
        end else if (ena) begin
            tag_v_q[0] <= rom_en;
            tag_o_q[0] <= owner_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_o_q[i] <= tag_o_q[i-1];
            end
        end
    end

    always_comb begin
        rom_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rom_rvalid[i] = ena && tag_v_q[ROM_LAT-1] && (tag_o_q[ROM_LAT-1] == OWNER_W'(i));
        end
    end

    assign rom_en      = granted & rd_own & ena;
    assign rom_addr    = granted ? addr_own : '0;
    assign rom_rdata   = (|rom_rvalid) ? rom_dout : '0;
    assign mac_opr1    = granted ? opr1_own : '0;
    assign mac_opr2    = granted ? opr2_own : '0;
    assign mac_valid   = ena ? gnt_q : '0;
    assign mac_res     = (|mac_valid) ? mac_dout : '0;
    assign mac_ovf     = (|mac_valid) & mac_ovf_in;
    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q | hold_hit;

endmodule
